store_unit: RTL and testbench
=============================

Name: store_unit

Overview:
Multicycle memory-write engine, the writer-side counterpart to the datapath's PC-driven instruction/data read path. Accepts one store request (word, halfword or byte) and drives the shared word-addressed memory port (address, write data, write enable). Sub-word stores use a read-modify-write sequence. Sits between unidadeControle (issues start/store_type) and Memoria.

Parameters:
READ_LATENCY, 1, cycles from mem_addr presented (mem_wr=0) to mem_rdata valid; legal range 1..7.

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; returns block to IDLE
start  in  1  request strobe, sampled only in IDLE
store_type  in  2  00=word (sw), 01=halfword (sh), 10=byte (sb), 11=reserved
addr  in  32  byte address of store
wdata  in  32  store data; sh uses [15:0], sb uses [7:0]
mem_rdata  in  32  memory read data
mem_addr  out  32  word-aligned memory address ({addr[31:2],2'b00})
mem_wdata  out  32  merged write data
mem_wr  out  1  memory write enable (1=write, 0=read)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done on rejected request

Behaviour:
- Reset (sync, high): state=IDLE; mem_addr=0, mem_wdata=0, mem_wr=0, busy=0, done=0, err=0; latency counter=0. Applies mid-operation: the next cycle has mem_wr=0 and no partial/pending write is issued later.
- Byte order is little-endian: byte offset k=addr[1:0] occupies mem word bits [8k+7:8k]; halfword at offset 0 -> [15:0], offset 2 -> [31:16].
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE: on start=1, latch addr, wdata, store_type.
  - type 11, word with addr[1:0]!=0, or half with addr[0]=1 -> ERR.
  - word -> WRITE. half/byte -> READ.
  - start while busy is ignored (not queued).
- READ (1 cycle): mem_addr=aligned addr, mem_wr=0; load counter=READ_LATENCY; -> WAIT.
- WAIT: decrement counter each cycle; on the cycle counter==1, capture mem_rdata, merge the selected byte/halfword of latched wdata into it (other bytes unchanged) -> WRITE. Occupies exactly READ_LATENCY cycles.
- WRITE (1 cycle): mem_wr=1, mem_addr=aligned addr, mem_wdata=word (wdata unmodified) or merged value -> DONE.
- DONE (1 cycle): done=1, mem_wr=0 -> IDLE.
- ERR (1 cycle): done=1, err=1, mem_wr never asserted for this request -> IDLE.
- mem_wr is high only in WRITE; never high two consecutive cycles.
- mem_addr/mem_wdata hold their last values outside READ/WAIT/WRITE (no glitching to 0 except at reset).
- Latency, start sampled at edge 0: word -> mem_wr in cycle 1, done in cycle 2; sub-word -> READ cycle 1, WAIT cycles 2..1+L, WRITE cycle 2+L, done cycle 3+L (L=READ_LATENCY). Earliest next start accepted the cycle after done.
- addr bits [31:2] pass through unchanged; no wrap or bounds check (memory range is the memory's concern).

Test Plan:
- Word store: reset, start, type=00, addr=0x0000_0010, wdata=0xDEAD_BEEF -> cycle 1: mem_wr=1, mem_addr=0x10, mem_wdata=0xDEADBEEF; cycle 2: done=1, err=0; no read cycle.
- Byte store, L=1: memory word at 0x20 = 0x1122_3344; start type=10, addr=0x23, wdata=0x0000_00AB -> READ cycle 1 (mem_addr=0x20, mem_wr=0), WRITE cycle 3 with mem_wdata=0xAB22_3344, done cycle 4.
- Halfword store, L=3: memory at 0x40 = 0xAAAA_BBBB; type=01, addr=0x42, wdata=0x1234_5678 -> WAIT lasts 3 cycles, mem_wdata=0x5678_BBBB, done at cycle 6.
- Misaligned/reserved: type=00 addr=0x06; type=01 addr=0x05; type=11 addr=0x00 -> each: done=1 and err=1 in cycle 1, mem_wr stays 0 throughout.
- Reset mid-op: byte store started, reset=1 during WAIT -> next cycle busy=0, mem_wr=0; mem_wr never asserts for the aborted store; a fresh word store then completes normally.
- Start while busy: second start pulsed during READ/WAIT of a byte store -> ignored; exactly one mem_wr pulse and one done pulse observed.

Source files
------------

// File: rtl/store_unit_if.sv
// Bus bundle between the store engine and its surroundings: the request
// side from the control unit plus the shared word-addressed memory port.
// The master side is whoever issues requests and owns the memory; the
// slave side is the store engine itself.
interface store_unit_if;
  logic        start;
  logic [1:0]  store_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, store_type, addr, wdata, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr, busy, done, err
  );

  modport slave (
    input  start, store_type, addr, wdata, mem_rdata,
    output mem_addr, mem_wdata, mem_wr, busy, done, err
  );
endinterface

// File: rtl/store_unit.sv
// Multicycle memory-write engine. Word stores go straight to a single write
// cycle; byte and halfword stores read the containing word, wait out the
// memory read latency, merge the new lane in (little-endian) and write the
// whole word back. Illegal requests finish in one cycle with err and never
// touch memory.
module store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  store_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] TYPE_WORD = 2'b00;
  localparam logic [1:0] TYPE_HALF = 2'b01;
  localparam logic [1:0] TYPE_BYTE = 2'b10;

  localparam logic [2:0] LATENCY = 3'(READ_LATENCY);

  state_t      state;
  state_t      next_state;

  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [15:0] lane_q;
  logic [1:0]  type_q;
  logic [1:0]  offset_q;
  logic [2:0]  cnt;

  logic        request_bad;
  logic [31:0] merged;

  // Reserved type, misaligned word or odd halfword address cannot be stored
  always_comb begin
    request_bad = 1'b0;
    case (bus.store_type)
      TYPE_WORD: request_bad = (bus.addr[1:0] != 2'b00);
      TYPE_HALF: request_bad = bus.addr[0];
      TYPE_BYTE: request_bad = 1'b0;
      default:   request_bad = 1'b1;
    endcase
  end

  // Overlay the latched byte/halfword onto the word coming back from memory
  always_comb begin
    merged = bus.mem_rdata;
    if (type_q == TYPE_BYTE) begin
      merged[{offset_q, 3'b000} +: 8] = lane_q[7:0];
    end else begin
      merged[{offset_q[1], 4'b0000} +: 16] = lane_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode and the purely state-derived handshake outputs
  always_comb begin
    next_state = state;
    bus.mem_wr = 1'b0;
    bus.busy   = 1'b1;
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          if (request_bad) begin
            next_state = ERR;
          end else if (bus.store_type == TYPE_WORD) begin
            next_state = WRITE;
          end else begin
            next_state = READ;
          end
        end
      end
      READ: begin
        next_state = WAIT;
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        bus.mem_wr = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        bus.done   = 1'b1;
        next_state = IDLE;
      end
      ERR: begin
        bus.done   = 1'b1;
        bus.err    = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Request latch, latency counter and memory address/data registers; the
  // memory-side registers only change when a legal request is taken or a
  // merge completes, so they hold steady in DONE/ERR/IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      lane_q      <= 16'd0;
      type_q      <= 2'b00;
      offset_q    <= 2'b00;
      cnt         <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !request_bad) begin
            mem_addr_q <= {bus.addr[31:2], 2'b00};
            lane_q     <= bus.wdata[15:0];
            type_q     <= bus.store_type;
            offset_q   <= bus.addr[1:0];
            if (bus.store_type == TYPE_WORD) begin
              mem_wdata_q <= bus.wdata;
            end
          end
        end
        READ: begin
          cnt <= LATENCY;
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            mem_wdata_q <= merged;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit. Two instances run side by side on the same
// request stream: one with a one-cycle read latency and one with three, each
// backed by its own small memory model whose read data trails the address
// by the instance's latency.
module tb_store_unit;

  logic clk;
  logic reset;

  store_unit_if bus_a ();
  store_unit_if bus_b ();

  store_unit #(.READ_LATENCY(1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  store_unit #(.READ_LATENCY(3)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  int wr_cnt_a;
  int wr_cnt_b;
  int done_cnt_a;
  int pass_count;
  int fail_count;
  int check_count;

  // Free-running clock
  always #5 clk = ~clk;

  // Memory models: write on mem_wr, read data delayed by the latency
  always @(posedge clk) begin
    if (bus_a.mem_wr) mem_a[bus_a.mem_addr[7:2]] <= bus_a.mem_wdata;
    if (bus_b.mem_wr) mem_b[bus_b.mem_addr[7:2]] <= bus_b.mem_wdata;
    pipe_a    <= mem_a[bus_a.mem_addr[7:2]];
    pipe_b[0] <= mem_b[bus_b.mem_addr[7:2]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign bus_a.mem_rdata = pipe_a;
  assign bus_b.mem_rdata = pipe_b[2];

  // Pulse counters for write enables and completions
  always @(posedge clk) begin
    if (bus_a.mem_wr) wr_cnt_a <= wr_cnt_a + 1;
    if (bus_b.mem_wr) wr_cnt_b <= wr_cnt_b + 1;
    if (bus_a.done)   done_cnt_a <= done_cnt_a + 1;
  end

  task automatic applyStimulus(input logic s, input logic [1:0] t,
                               input logic [31:0] a, input logic [31:0] d);
    bus_a.start = s; bus_a.store_type = t; bus_a.addr = a; bus_a.wdata = d;
    bus_b.start = s; bus_b.store_type = t; bus_b.addr = a; bus_b.wdata = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  int wr_snap;
  int done_snap;

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    wr_cnt_a = 0; wr_cnt_b = 0; done_cnt_a = 0;
    pass_count = 0; fail_count = 0; check_count = 0;
    pipe_a = 32'h0;
    for (int i = 0; i < 3; i++) pipe_b[i] = 32'h0;
    for (int i = 0; i < 64; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    mem_a[8]  = 32'h1122_3344;
    mem_b[16] = 32'hAAAA_BBBB;
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset state
    idle(2);
    checkOutput("rst_busy",  bus_a.busy,      32'd0);
    checkOutput("rst_wr",    bus_a.mem_wr,    32'd0);
    checkOutput("rst_done",  bus_a.done,      32'd0);
    checkOutput("rst_err",   bus_a.err,       32'd0);
    checkOutput("rst_addr",  bus_a.mem_addr,  32'd0);
    checkOutput("rst_wdata", bus_a.mem_wdata, 32'd0);
    reset = 1'b0;
    idle(1);

    // Word store: write in cycle 1, done in cycle 2
    wr_snap = wr_cnt_a;
    applyStimulus(1'b1, 2'b00, 32'h0000_0010, 32'hDEAD_BEEF);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("sw_c1_wr",    bus_a.mem_wr,    32'd1);
    checkOutput("sw_c1_addr",  bus_a.mem_addr,  32'h0000_0010);
    checkOutput("sw_c1_wdata", bus_a.mem_wdata, 32'hDEAD_BEEF);
    step();
    checkOutput("sw_c2_done",  bus_a.done,      32'd1);
    checkOutput("sw_c2_err",   bus_a.err,       32'd0);
    checkOutput("sw_c2_wr",    bus_a.mem_wr,    32'd0);
    checkOutput("sw_c2_addr",  bus_a.mem_addr,  32'h0000_0010);
    step();
    checkOutput("sw_c3_busy",  bus_a.busy,      32'd0);
    checkOutput("sw_wr_pulses", 32'(wr_cnt_a - wr_snap), 32'd1);
    idle(4);

    // Byte store, L=1, with a second start held high during READ and WAIT
    wr_snap = wr_cnt_a;
    done_snap = done_cnt_a;
    applyStimulus(1'b1, 2'b10, 32'h0000_0023, 32'h0000_00AB);
    step();
    checkOutput("sb_c1_addr", bus_a.mem_addr, 32'h0000_0020);
    checkOutput("sb_c1_wr",   bus_a.mem_wr,   32'd0);
    checkOutput("sb_c1_busy", bus_a.busy,     32'd1);
    applyStimulus(1'b1, 2'b00, 32'h0000_0030, 32'h5555_5555);
    step();
    checkOutput("sb_c2_wr",   bus_a.mem_wr,   32'd0);
    checkOutput("sb_c2_addr", bus_a.mem_addr, 32'h0000_0020);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("sb_c3_wr",    bus_a.mem_wr,    32'd1);
    checkOutput("sb_c3_addr",  bus_a.mem_addr,  32'h0000_0020);
    checkOutput("sb_c3_wdata", bus_a.mem_wdata, 32'hAB22_3344);
    step();
    checkOutput("sb_c4_done", bus_a.done,   32'd1);
    checkOutput("sb_c4_err",  bus_a.err,    32'd0);
    checkOutput("sb_c4_wr",   bus_a.mem_wr, 32'd0);
    step();
    checkOutput("sb_c5_busy", bus_a.busy, 32'd0);
    idle(6);
    checkOutput("sb_mem",         mem_a[8],                  32'hAB22_3344);
    checkOutput("busy_wr_pulses", 32'(wr_cnt_a - wr_snap),   32'd1);
    checkOutput("busy_done_pulses", 32'(done_cnt_a - done_snap), 32'd1);

    // Halfword store, L=3: WAIT spans cycles 2..4, write cycle 5, done 6
    applyStimulus(1'b1, 2'b01, 32'h0000_0042, 32'h1234_5678);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("sh_c1_addr", bus_b.mem_addr, 32'h0000_0040);
    checkOutput("sh_c1_wr",   bus_b.mem_wr,   32'd0);
    step();
    checkOutput("sh_c2_wr", bus_b.mem_wr, 32'd0);
    step();
    checkOutput("sh_c3_wr", bus_b.mem_wr, 32'd0);
    step();
    checkOutput("sh_c4_wr",   bus_b.mem_wr, 32'd0);
    checkOutput("sh_c4_busy", bus_b.busy,   32'd1);
    step();
    checkOutput("sh_c5_wr",    bus_b.mem_wr,    32'd1);
    checkOutput("sh_c5_wdata", bus_b.mem_wdata, 32'h5678_BBBB);
    step();
    checkOutput("sh_c6_done", bus_b.done, 32'd1);
    checkOutput("sh_c6_err",  bus_b.err,  32'd0);
    idle(4);
    checkOutput("sh_mem", mem_b[16], 32'h5678_BBBB);

    // Rejected requests: done+err in cycle 1, no write, addr held
    wr_snap = wr_cnt_a;
    applyStimulus(1'b1, 2'b00, 32'h0000_0006, 32'h0);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("err_sw_done", bus_a.done, 32'd1);
    checkOutput("err_sw_err",  bus_a.err,  32'd1);
    checkOutput("err_sw_wr",   bus_a.mem_wr, 32'd0);
    checkOutput("err_sw_addr", bus_a.mem_addr, 32'h0000_0040);
    step();
    checkOutput("err_sw_c2_busy", bus_a.busy, 32'd0);
    checkOutput("err_sw_c2_err",  bus_a.err,  32'd0);
    applyStimulus(1'b1, 2'b01, 32'h0000_0005, 32'h0);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("err_sh_done", bus_a.done, 32'd1);
    checkOutput("err_sh_err",  bus_a.err,  32'd1);
    step();
    applyStimulus(1'b1, 2'b11, 32'h0000_0000, 32'h0);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("err_rsv_done", bus_a.done, 32'd1);
    checkOutput("err_rsv_err",  bus_a.err,  32'd1);
    idle(3);
    checkOutput("err_wr_pulses", 32'(wr_cnt_a - wr_snap), 32'd0);

    // Reset during WAIT of a byte store, then a fresh word store
    wr_snap = wr_cnt_b;
    applyStimulus(1'b1, 2'b10, 32'h0000_0021, 32'h0000_00CD);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    step();
    checkOutput("rmo_c2_busy", bus_b.busy, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rmo_busy", bus_b.busy,   32'd0);
    checkOutput("rmo_wr",   bus_b.mem_wr, 32'd0);
    checkOutput("rmo_addr", bus_b.mem_addr, 32'd0);
    idle(6);
    checkOutput("rmo_wr_pulses", 32'(wr_cnt_b - wr_snap), 32'd0);
    applyStimulus(1'b1, 2'b00, 32'h0000_0008, 32'h0BAD_F00D);
    step();
    applyStimulus(1'b0, 2'b00, 32'h0, 32'h0);
    checkOutput("rmo_sw_wr",    bus_b.mem_wr,    32'd1);
    checkOutput("rmo_sw_addr",  bus_b.mem_addr,  32'h0000_0008);
    checkOutput("rmo_sw_wdata", bus_b.mem_wdata, 32'h0BAD_F00D);
    step();
    checkOutput("rmo_sw_done", bus_b.done, 32'd1);
    idle(2);
    checkOutput("rmo_sw_mem", mem_b[2], 32'h0BAD_F00D);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
